// File: rtl/cd_bus_pkg.sv
// rtl/cd_bus_pkg.sv - shared state encodings and default widths for the CPU data-bus port
package cd_bus_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cd_bus_pad.sv
// rtl/cd_bus_pad.sv - parametrised tristate pad for a shared bidirectional bus
module cd_bus_pad #(
    parameter int WIDTH = cd_bus_pkg::DEF_WIDTH
) (
    input  logic             drive_en,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = drive_en ? dout : {WIDTH{1'bz}};
    assign din = bus;

endmodule

// File: rtl/cd_bus_port.sv
// rtl/cd_bus_port.sv - handshaked CPU data-bus port: latches one request, runs the bus access, reports done/timeout
module cd_bus_port
    import cd_bus_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic [WIDTH-1:0]      cpu_rdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    inout  wire  [WIDTH-1:0]      bus_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_read,
    output logic                  bus_write,
    input  logic                  bus_ready
);

    // Last counter value before giving up; unused when TIMEOUT is 0.
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      bus_din;

    cd_bus_pad #(.WIDTH(WIDTH)) u_pad (
        .drive_en (state_q == ST_WRITE),
        .dout     (wdata_q),
        .din      (bus_din),
        .bus      (bus_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    cnt_d   = 8'd0;
                    state_d = cpu_we ? ST_WRITE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (bus_ready) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    if (state_q == ST_READ) begin
                        rdata_d = bus_din;
                    end
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = (state_q != ST_IDLE);
    assign cpu_done  = (state_q == ST_DONE);
    assign cpu_err   = (state_q == ST_DONE) && err_q;
    assign bus_read  = (state_q == ST_READ);
    assign bus_write = (state_q == ST_WRITE);
    assign bus_addr  = (state_q == ST_IDLE) ? '0 : addr_q;

endmodule

// File: tb/tb_cd_bus_port.sv
// tb/tb_cd_bus_port.sv - directed table-driven bench for cd_bus_port
module tb_cd_bus_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, rdy, tdrv;
    logic [15:0] addr, wdata, tdat;
    logic [15:0] rdata, baddr;
    logic        busy, done, err, brd, bwr;
    wire  [15:0] bus;

    logic        req0, rdy0, tdrv0;
    logic [15:0] tdat0;
    logic [15:0] rdata0, baddr0;
    logic        busy0, done0, err0, brd0, bwr0;
    wire  [15:0] bus0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign bus  = tdrv  ? tdat  : 16'bz;
    assign bus0 = tdrv0 ? tdat0 : 16'bz;

    cd_bus_port #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(rst_n), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_busy(busy), .cpu_done(done),
        .cpu_err(err), .bus_data(bus), .bus_addr(baddr), .bus_read(brd),
        .bus_write(bwr), .bus_ready(rdy)
    );

    cd_bus_port #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .cpu_req(req0), .cpu_we(1'b0), .cpu_addr(16'h0400),
        .cpu_wdata(16'h0000), .cpu_rdata(rdata0), .cpu_busy(busy0), .cpu_done(done0),
        .cpu_err(err0), .bus_data(bus0), .bus_addr(baddr0), .bus_read(brd0),
        .bus_write(bwr0), .bus_ready(rdy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rd_wr_exclusive", {31'd0, brd & bwr}, 32'd0);
        check("rd_wr_exclusive0", {31'd0, brd0 & bwr0}, 32'd0);
    end

    typedef struct {
        logic        rst_n, req, we;
        logic [15:0] addr, wdata;
        logic        rdy, tdrv;
        logic [15:0] tdat;
        logic        busy, done, err, rd, wr;
        logic [15:0] eaddr, erdata;
        logic        chk_bus;
        logic [15:0] ebus;
    } vec_t;

    vec_t vec[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_cycles;
        logic ok;

        //          rst req we addr      wdata     rdy drv tdat     busy done err rd wr eaddr     erdata  chk ebus
        vec[0]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
        vec[1]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
        vec[2]  = '{1, 1, 1, 16'h0040, 16'hBEEF, 1, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0040, 16'h0000, 1, 16'hBEEF};
        vec[3]  = '{1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0040, 16'h0000, 0, 16'h0000};
        vec[4]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
        vec[5]  = '{1, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000};
        vec[6]  = '{1, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000};
        vec[7]  = '{1, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000};
        vec[8]  = '{1, 1, 0, 16'h0100, 16'h0000, 1, 1, 16'h1234, 1, 1, 0, 0, 0, 16'h0100, 16'h1234, 0, 16'h0000};
        vec[9]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 16'h0000};
        vec[10] = '{1, 1, 1, 16'h0A0A, 16'h5555, 1, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0A0A, 16'h1234, 1, 16'h5555};
        vec[11] = '{1, 1, 0, 16'h0B0B, 16'h1111, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0A0A, 16'h1234, 1, 16'h5555};
        vec[12] = '{1, 1, 0, 16'h0B0B, 16'h1111, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0A0A, 16'h1234, 0, 16'h0000};
        vec[13] = '{1, 1, 0, 16'h0B0B, 16'h1111, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 16'h0000};
        vec[14] = '{1, 1, 0, 16'h0B0B, 16'h1111, 1, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0B0B, 16'h1234, 0, 16'h0000};
        vec[15] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hCAFE, 1, 1, 0, 0, 0, 16'h0B0B, 16'hCAFE, 0, 16'h0000};
        vec[16] = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'hCAFE, 0, 16'h0000};

        req0 = 0; rdy0 = 0; tdrv0 = 0; tdat0 = 16'h0000;

        for (int i = 0; i < 17; i++) begin
            rst_n = vec[i].rst_n; req = vec[i].req; we = vec[i].we;
            addr = vec[i].addr; wdata = vec[i].wdata;
            rdy = vec[i].rdy; tdrv = vec[i].tdrv; tdat = vec[i].tdat;
            step();
            check($sformatf("v%0d.busy", i),  {31'd0, busy}, {31'd0, vec[i].busy});
            check($sformatf("v%0d.done", i),  {31'd0, done}, {31'd0, vec[i].done});
            check($sformatf("v%0d.err", i),   {31'd0, err},  {31'd0, vec[i].err});
            check($sformatf("v%0d.read", i),  {31'd0, brd},  {31'd0, vec[i].rd});
            check($sformatf("v%0d.write", i), {31'd0, bwr},  {31'd0, vec[i].wr});
            check($sformatf("v%0d.addr", i),  {16'd0, baddr}, {16'd0, vec[i].eaddr});
            check($sformatf("v%0d.rdata", i), {16'd0, rdata}, {16'd0, vec[i].erdata});
            if (vec[i].chk_bus) begin
                check($sformatf("v%0d.bus", i), {16'd0, bus}, {16'd0, vec[i].ebus});
            end
        end

        // Timeout: read with no ready after a fresh reset.
        rst_n = 0; req = 0; rdy = 0; tdrv = 0;
        step();
        rst_n = 1;
        step();
        check("to.rdata_reset", {16'd0, rdata}, 32'd0);
        req = 1; we = 0; addr = 16'h0200;
        step();
        req = 0;
        rd_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            if (brd) rd_cycles++;
            step();
        end
        check("to.read_cycles", rd_cycles, 32'd15);
        check("to.done", {31'd0, done}, 32'd1);
        check("to.err", {31'd0, err}, 32'd1);
        check("to.rdata_held", {16'd0, rdata}, 32'd0);
        step();
        check("to.idle_busy", {31'd0, busy}, 32'd0);
        check("to.idle_err", {31'd0, err}, 32'd0);

        // Reset during a write wait cycle.
        req = 1; we = 1; addr = 16'h0300; wdata = 16'hAAAA; rdy = 0;
        step();
        req = 0;
        check("rst.write1", {31'd0, bwr}, 32'd1);
        step();
        check("rst.write2", {31'd0, bwr}, 32'd1);
        check("rst.bus", {16'd0, bus}, 32'h0000AAAA);
        rst_n = 0;
        step();
        check("rst.write_off", {31'd0, bwr}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.addr", {16'd0, baddr}, 32'd0);
        rst_n = 1;
        step();
        check("rst.no_done", {31'd0, done}, 32'd0);
        check("rst.idle", {31'd0, busy}, 32'd0);

        // TIMEOUT=0 instance waits indefinitely.
        req0 = 1;
        step();
        req0 = 0;
        ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!(busy0 && brd0 && !done0)) ok = 1'b0;
            step();
        end
        check("nto.waiting", {31'd0, ok}, 32'd1);
        rdy0 = 1; tdrv0 = 1; tdat0 = 16'h7777;
        step();
        check("nto.done", {31'd0, done0}, 32'd1);
        check("nto.err", {31'd0, err0}, 32'd0);
        check("nto.rdata", {16'd0, rdata0}, 32'h00007777);
        rdy0 = 0; tdrv0 = 0;
        step();
        check("nto.idle", {31'd0, busy0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
